// File: rtl/periph_bus_pkg.sv
// -----------------------------------------------------------------------------
// periph_bus_pkg
// Shared types and constants for the simple peripheral bus initiator.
//   PB_ADDR_W     word address width (byte address [15:2])
//   PB_DATA_W     data width
//   PB_BE_W       byte-enable width
//   PB_ERR_RDATA  read data returned when a read times out
//   pb_state_e    initiator FSM states
//   pb_sat_inc8   saturating increment used by the timeout counter
// -----------------------------------------------------------------------------
package periph_bus_pkg;

   localparam int PB_ADDR_W = 14;
   localparam int PB_DATA_W = 32;
   localparam int PB_BE_W   = 4;

   localparam logic [PB_DATA_W-1:0] PB_ERR_RDATA = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WR_ISSUE = 3'd3,
      RSP      = 3'd4
   } pb_state_e;

   function automatic logic [7:0] pb_sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/periph_bus_initiator.sv
// -----------------------------------------------------------------------------
// periph_bus_initiator
// Initiator side of the simple peripheral bus. Takes one command at a time from
// a valid/ready port, issues a single-cycle OE (read) or WE (write) strobe and
// returns a response on a valid/ready response port. Reads wait up to TIMEOUT
// cycles for RD_VALID and report an error response on timeout.
//
// Handshake rules: a command transfers on a cycle where req_valid && req_ready;
// a response transfers on a cycle where rsp_valid && rsp_ready. rsp_valid and
// the rsp_* payload stay constant until that transfer happens.
//
// Ports
//   CLK, RSTn                 clock (posedge) / synchronous active-low reset
//   req_valid/ready           command handshake (ready only in IDLE)
//   req_write/addr/wdata/be   command payload
//   rsp_valid/ready           response handshake
//   rsp_rdata, rsp_err        response payload (rdata 0 for writes)
//   err_count                 saturating count of read timeouts
//   RD_ADDR, OE               peripheral read address / read strobe
//   RD_DATA, RD_VALID         peripheral read data / data valid
//   WR_ADDR, WR_DATA, WE, BE  peripheral write address/data/strobe/byte enables
// -----------------------------------------------------------------------------
module periph_bus_initiator
   import periph_bus_pkg::*;
#(
   parameter int                    TIMEOUT   = 16,
   parameter logic [PB_DATA_W-1:0]  ERR_RDATA = PB_ERR_RDATA
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [PB_ADDR_W-1:0]  req_addr,
   input  logic [PB_DATA_W-1:0]  req_wdata,
   input  logic [PB_BE_W-1:0]    req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [PB_DATA_W-1:0]  rsp_rdata,
   output logic                  rsp_err,
   output logic [7:0]            err_count,
   output logic [PB_ADDR_W-1:0]  RD_ADDR,
   output logic                  OE,
   input  logic [PB_DATA_W-1:0]  RD_DATA,
   input  logic                  RD_VALID,
   output logic [PB_ADDR_W-1:0]  WR_ADDR,
   output logic [PB_DATA_W-1:0]  WR_DATA,
   output logic                  WE,
   output logic [PB_BE_W-1:0]    BE
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // Counter value on the final wait cycle, c(1+TIMEOUT) relative to accept.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   pb_state_e              state_q, state_d;
   logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
   logic                   oe_q, oe_d;
   logic [PB_ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                   we_q, we_d;
   logic [PB_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [PB_DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [PB_BE_W-1:0]     be_q, be_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [PB_DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                   rsp_err_q, rsp_err_d;
   logic [7:0]             err_count_q, err_count_d;

   logic                   wait_last;

   assign wait_last = (wait_cnt_q == CNT_LAST);

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         oe_q        <= 1'b0;
         rd_addr_q   <= '0;
         we_q        <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         be_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         oe_q        <= oe_d;
         rd_addr_q   <= rd_addr_d;
         we_q        <= we_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         be_q        <= be_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         err_count_q <= err_count_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (req_valid) state_d = req_write ? WR_ISSUE : RD_ISSUE;
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT:  if (RD_VALID || wait_last) state_d = RSP;
         WR_ISSUE: state_d = RSP;
         RSP:      if (rsp_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output / datapath logic. Strobes and BE default low so they last exactly
   // one cycle; addresses and write data hold their last value.
   // ------------------------------------------------------------------------
   always_comb begin
      wait_cnt_d  = wait_cnt_q;
      oe_d        = 1'b0;
      rd_addr_d   = rd_addr_q;
      we_d        = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      be_d        = '0;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      err_count_d = err_count_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_write) begin
                  we_d      = 1'b1;
                  wr_addr_d = req_addr;
                  wr_data_d = req_wdata;
                  be_d      = req_be;
               end else begin
                  oe_d      = 1'b1;
                  rd_addr_d = req_addr;
               end
            end
         end
         // RD_VALID during the OE cycle is ignored; the counter is primed so
         // that it reads 0 on the first sampled wait cycle.
         RD_ISSUE: wait_cnt_d = '0;
         RD_WAIT: begin
            if (RD_VALID) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = RD_DATA;
               rsp_err_d   = 1'b0;
            end else if (wait_last) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = ERR_RDATA;
               rsp_err_d   = 1'b1;
               err_count_d = pb_sat_inc8(err_count_q);
            end else begin
               wait_cnt_d  = wait_cnt_q + CNT_W'(1);
            end
         end
         WR_ISSUE: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
         end
         RSP: if (rsp_ready) rsp_valid_d = 1'b0;
         default: ;
      endcase
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign err_count = err_count_q;
   assign RD_ADDR   = rd_addr_q;
   assign OE        = oe_q;
   assign WR_ADDR   = wr_addr_q;
   assign WR_DATA   = wr_data_q;
   assign WE        = we_q;
   assign BE        = be_q;

endmodule

// File: tb/tb_periph_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_periph_bus_initiator
// Directed and randomized transactions for periph_bus_initiator. Each
// transaction's expected timeline (strobe cycle, response cycle, payload,
// timeout count) is computed from the bus rules in do_txn and compared cycle
// by cycle at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_periph_bus_initiator;

  localparam int          TIMEOUT   = 16;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  err_count;
  logic [13:0] RD_ADDR;
  logic        OE;
  logic [31:0] RD_DATA;
  logic        RD_VALID;
  logic [13:0] WR_ADDR;
  logic [31:0] WR_DATA;
  logic        WE;
  logic [3:0]  BE;

  int checks   = 0;
  int failures = 0;
  int exp_errs = 0;

  always #5 CLK = ~CLK;

  periph_bus_initiator #(.TIMEOUT(TIMEOUT), .ERR_RDATA(ERR_RDATA)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .err_count(err_count),
    .RD_ADDR(RD_ADDR), .OE(OE), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WE(WE), .BE(BE)
  );

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("%s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_rd_addr",   32'(RD_ADDR), 32'd0);
    chk("rst_oe",        32'(OE), 32'd0);
    chk("rst_wr_addr",   32'(WR_ADDR), 32'd0);
    chk("rst_wr_data",   WR_DATA, 32'd0);
    chk("rst_we",        32'(WE), 32'd0);
    chk("rst_be",        32'(BE), 32'd0);
  endtask

  // Idle cycles with stray RD_VALID pulses, which must have no effect.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      req_valid = 1'b0;
      rsp_ready = 1'($urandom_range(0, 1));
      RD_VALID  = 1'($urandom_range(0, 1));
      RD_DATA   = $urandom;
      @(negedge CLK);
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      chk("idle_oe",        32'(OE), 32'd0);
      chk("idle_we",        32'(WE), 32'd0);
      chk("idle_be",        32'(BE), 32'd0);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle_err_count", 32'(err_count), 32'(exp_errs));
    end
  endtask

  // One transaction accepted at c0. For reads, RD_VALID pulses once at cycle
  // c(1+lat) (lat<0: never). The read succeeds only if that pulse lands in the
  // wait window c2..c(1+TIMEOUT). rsp_ready is held low for 'stall' cycles
  // after the response appears. With 'hold', another request stays valid
  // throughout, and must not be taken until the response handshake is done.
  task automatic do_txn(input bit wr, input logic [13:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int lat, input logic [31:0] rdata,
                        input int stall, input bit hold);
    bit          ok;
    int          rsp_c;
    int          hs_c;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          old_errs;
    ok       = !wr && (lat >= 1) && (lat <= TIMEOUT);
    rsp_c    = wr ? 2 : (ok ? 2 + lat : 2 + TIMEOUT);
    hs_c     = rsp_c + stall;
    exp_rd   = wr ? 32'd0 : (ok ? rdata : ERR_RDATA);
    exp_err  = !wr && !ok;
    old_errs = exp_errs;
    if (exp_err && exp_errs < 255) exp_errs++;

    step();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    RD_VALID  = 1'b0;
    RD_DATA   = $urandom;
    rsp_ready = 1'($urandom_range(0, 1));
    @(negedge CLK);
    chk("c0_req_ready", 32'(req_ready), 32'd1);
    chk("c0_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("c0_oe",        32'(OE), 32'd0);
    chk("c0_we",        32'(WE), 32'd0);

    for (int k = 1; k <= hs_c; k++) begin
      step();
      req_valid = hold;
      req_write = ~wr;
      req_addr  = 14'($urandom);
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      RD_VALID  = (k == 1 + lat);
      RD_DATA   = (k == 1 + lat) ? rdata : $urandom;
      rsp_ready = (k >= hs_c) ? 1'b1 : ((k < rsp_c) ? 1'($urandom_range(0, 1)) : 1'b0);
      @(negedge CLK);
      chk("oe",        32'(OE), 32'(!wr && k == 1));
      chk("we",        32'(WE), 32'(wr && k == 1));
      chk("be",        32'(BE), (wr && k == 1) ? 32'(be) : 32'd0);
      chk("req_ready", 32'(req_ready), 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(k >= rsp_c));
      chk("err_count", 32'(err_count), (k >= rsp_c) ? 32'(exp_errs) : 32'(old_errs));
      if (!wr) chk("rd_addr", 32'(RD_ADDR), 32'(addr));
      if (wr && k == 1) begin
        chk("wr_addr", 32'(WR_ADDR), 32'(addr));
        chk("wr_data", WR_DATA, wdata);
      end
      if (k >= rsp_c) begin
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err",   32'(rsp_err), 32'(exp_err));
      end
    end
  endtask

  initial begin
    RSTn      = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    RD_DATA   = '0;
    RD_VALID  = 1'b0;

    // Reset state
    repeat (3) step();
    @(negedge CLK);
    chk_reset_state();
    step();
    RSTn = 1'b1;
    idle(2);

    // 1: read with one-cycle responder
    do_txn(1'b0, 14'h0010, 32'd0, 4'd0, 1, 32'h0000_002A, 0, 1'b0);
    // 2: write
    do_txn(1'b1, 14'h0004, 32'h1234_5678, 4'b0011, -1, 32'd0, 0, 1'b0);
    // 3: timeout with late RD_VALID at c18, then success on the last wait cycle
    do_txn(1'b0, 14'h0123, 32'd0, 4'd0, TIMEOUT + 1, 32'h5555_AAAA, 0, 1'b0);
    do_txn(1'b0, 14'h0124, 32'd0, 4'd0, TIMEOUT, 32'hCAFE_F00D, 0, 1'b0);
    // RD_VALID only during the OE cycle is ignored -> timeout
    do_txn(1'b0, 14'h0200, 32'd0, 4'd0, 0, 32'h1111_1111, 0, 1'b0);
    // 4: response back-pressure with a pending request, then immediate next request
    do_txn(1'b0, 14'h0300, 32'd0, 4'd0, 3, 32'h0BAD_F00D, 5, 1'b1);
    do_txn(1'b1, 14'h3FFF, 32'hFFFF_0000, 4'b1111, -1, 32'd0, 5, 1'b1);
    do_txn(1'b0, 14'h0301, 32'd0, 4'd0, 2, 32'h7777_8888, 0, 1'b0);
    idle(3);

    // Randomized mix
    for (int i = 0; i < 150; i++) begin
      bit wr;
      int lat;
      wr  = 1'($urandom_range(0, 1));
      lat = int'($urandom_range(0, TIMEOUT + 3)) - 1;
      do_txn(wr, 14'($urandom), $urandom, 4'($urandom), lat, $urandom,
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    // 5: reset during RD_WAIT, late RD_VALID afterwards
    step();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h0042;
    rsp_ready = 1'b1; RD_VALID = 1'b0;
    step(); req_valid = 1'b0;
    step();
    step();
    step(); RSTn = 1'b0;
    step(); RSTn = 1'b1; RD_VALID = 1'b1; RD_DATA = 32'h1234_ABCD;
    exp_errs = 0;
    @(negedge CLK);
    chk_reset_state();
    idle(4);

    // 6: 260 back-to-back timeouts saturate err_count at 255
    for (int i = 0; i < 260; i++)
      do_txn(1'b0, 14'($urandom), 32'd0, 4'd0, -1, 32'd0, 0, 1'b0);
    idle(1);
    chk("err_count_sat", 32'(err_count), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
